// File: rtl/sdcard_writer.sv
// RAM-to-SD dump engine: copies MAX_RAM_ADDRESS 16-bit words into 512-byte SD blocks, low byte first.
// Optional running word checksum is built only when SDCARD_WR_CHECKSUM_EN is defined.
module sdcard_writer #(
  parameter logic [24:0] MAX_RAM_ADDRESS = 25'h266F78,
  parameter logic        SDHC            = 1'b1
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        start,
  output logic        ram_re,
  output logic [24:0] ram_address,
  input  logic [15:0] ram_rdata,
  input  logic        ram_rvalid,
  output logic        sd_wr,
  output logic        sd_continue,
  output logic [31:0] sd_block_addr,
  output logic [7:0]  sd_data,
  output logic        sd_data_next,
  input  logic        sd_data_ack,
  input  logic        sd_busy,
  input  logic [15:0] sd_error,
  output logic        wr_done,
  output logic        wr_error,
  output logic [15:0] checksum
);

  typedef enum logic [3:0] {
    IDLE, WRBLOCK, FETCH, WRL_0, WRL_1, WRH_0, WRH_1, PAD_0, PAD_1, ERROR, DONE
  } state_t;

  state_t      state, state_next;
  logic [24:0] addr, addr_next, addr_inc;
  logic [15:0] word, word_next;
  logic [8:0]  pad_cnt, pad_next, fill;
  logic [31:0] addr32;
  logic        sd_fault;

  assign addr32        = {7'b0, addr};
  assign sd_block_addr = SDHC ? (addr32 >> 8) : (addr32 << 1);
  assign ram_address   = addr;
  assign addr_inc      = addr + 25'd1;
  // bytes already in the block (2 per word) plus pad bytes sent so far
  assign fill          = {addr[7:0], 1'b0} + pad_cnt;
  assign sd_fault      = !sd_busy && (sd_error != '0);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      word    <= '0;
      pad_cnt <= '0;
    end else begin
      state   <= state_next;
      addr    <= addr_next;
      word    <= word_next;
      pad_cnt <= pad_next;
    end
  end

  always_comb begin
    state_next   = state;
    addr_next    = addr;
    word_next    = word;
    pad_next     = pad_cnt;
    sd_wr        = 1'b0;
    sd_continue  = 1'b0;
    sd_data_next = 1'b0;
    ram_re       = 1'b0;
    wr_done      = 1'b0;
    wr_error     = 1'b0;
    case (state)
      IDLE: begin
        if (sd_fault)
          state_next = ERROR;
        else if (start && !sd_busy)
          state_next = WRBLOCK;
      end
      WRBLOCK: begin
        if (addr >= MAX_RAM_ADDRESS) begin
          state_next = DONE;
        end else begin
          sd_wr       = 1'b1;
          sd_continue = (sd_block_addr != '0);
          if (sd_busy)
            state_next = FETCH;
        end
      end
      FETCH: begin
        ram_re = 1'b1;
        if (ram_rvalid) begin
          word_next  = ram_rdata;
          state_next = WRL_0;
        end
      end
      WRL_0: begin
        sd_data_next = 1'b1;
        if (sd_data_ack) state_next = WRL_1;
      end
      WRL_1: if (!sd_data_ack) state_next = WRH_0;
      WRH_0: begin
        sd_data_next = 1'b1;
        if (sd_data_ack) state_next = WRH_1;
      end
      WRH_1: begin
        if (!sd_data_ack) begin
          addr_next = addr_inc;
          if (addr_inc[7:0] == 8'd0) begin
            state_next = WRBLOCK;
          end else if (addr_inc >= MAX_RAM_ADDRESS) begin
            pad_next   = '0;
            state_next = PAD_0;
          end else begin
            state_next = FETCH;
          end
        end
      end
      PAD_0: begin
        sd_data_next = 1'b1;
        if (sd_data_ack) state_next = PAD_1;
      end
      PAD_1: begin
        if (!sd_data_ack) begin
          if (fill == 9'h1FF) begin
            pad_next   = '0;
            state_next = WRBLOCK;
          end else begin
            pad_next   = pad_cnt + 9'd1;
            state_next = PAD_0;
          end
        end
      end
      ERROR:   wr_error = 1'b1;
      DONE:    wr_done  = 1'b1;
      default: state_next = IDLE;
    endcase
    // a controller fault overrides any transition while a block is in flight
    if (sd_fault && (state inside {WRBLOCK, FETCH, WRL_0, WRL_1, WRH_0, WRH_1, PAD_0, PAD_1}))
      state_next = ERROR;
  end

  always_comb begin
    sd_data = '0;
    case (state)
      WRL_0, WRL_1: sd_data = word[7:0];
      WRH_0, WRH_1: sd_data = word[15:8];
      default:      sd_data = '0;
    endcase
  end

`ifdef SDCARD_WR_CHECKSUM_EN
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)
      checksum <= '0;
    else if (state == FETCH && ram_rvalid)
      checksum <= checksum + ram_rdata;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sdcard_writer.sv
// Scoreboard bench for sdcard_writer: three instances (SDHC multi-block with padding, byte addressing, checksum wrap).
module tb_sdcard_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start_bc, inject;
  int   n_cmp = 0, n_err = 0;

`ifdef SDCARD_WR_CHECKSUM_EN
  localparam logic [15:0] A_SUM = 16'hAF32;
  localparam logic [15:0] C_SUM = 16'h0001;
`else
  localparam logic [15:0] A_SUM = 16'h0000;
  localparam logic [15:0] C_SUM = 16'h0000;
`endif

  // instance A: MAX=300, SDHC=1
  logic        a_ram_re, a_ram_rvalid, a_sd_wr, a_sd_continue, a_sd_data_next, a_sd_data_ack;
  logic        a_sd_busy, a_wr_done, a_wr_error;
  logic [24:0] a_ram_address;
  logic [15:0] a_ram_rdata, a_sd_error, a_checksum;
  logic [31:0] a_sd_block_addr;
  logic [7:0]  a_sd_data;
  // instance B: MAX=512, SDHC=0
  logic        b_ram_re, b_ram_rvalid, b_sd_wr, b_sd_continue, b_sd_data_next, b_sd_data_ack;
  logic        b_sd_busy, b_wr_done, b_wr_error;
  logic [24:0] b_ram_address;
  logic [15:0] b_ram_rdata, b_checksum;
  logic [31:0] b_sd_block_addr;
  logic [7:0]  b_sd_data;
  // instance C: MAX=2, SDHC=1
  logic        c_ram_re, c_ram_rvalid, c_sd_wr, c_sd_continue, c_sd_data_next, c_sd_data_ack;
  logic        c_sd_busy, c_wr_done, c_wr_error;
  logic [24:0] c_ram_address;
  logic [15:0] c_ram_rdata, c_checksum;
  logic [31:0] c_sd_block_addr;
  logic [7:0]  c_sd_data;

  sdcard_writer #(.MAX_RAM_ADDRESS(25'd300), .SDHC(1'b1)) dut_a (
    .clk50(clk), .reset(rst), .start(start),
    .ram_re(a_ram_re), .ram_address(a_ram_address), .ram_rdata(a_ram_rdata), .ram_rvalid(a_ram_rvalid),
    .sd_wr(a_sd_wr), .sd_continue(a_sd_continue), .sd_block_addr(a_sd_block_addr), .sd_data(a_sd_data),
    .sd_data_next(a_sd_data_next), .sd_data_ack(a_sd_data_ack), .sd_busy(a_sd_busy), .sd_error(a_sd_error),
    .wr_done(a_wr_done), .wr_error(a_wr_error), .checksum(a_checksum));

  sdcard_writer #(.MAX_RAM_ADDRESS(25'd512), .SDHC(1'b0)) dut_b (
    .clk50(clk), .reset(rst), .start(start_bc),
    .ram_re(b_ram_re), .ram_address(b_ram_address), .ram_rdata(b_ram_rdata), .ram_rvalid(b_ram_rvalid),
    .sd_wr(b_sd_wr), .sd_continue(b_sd_continue), .sd_block_addr(b_sd_block_addr), .sd_data(b_sd_data),
    .sd_data_next(b_sd_data_next), .sd_data_ack(b_sd_data_ack), .sd_busy(b_sd_busy), .sd_error(16'h0000),
    .wr_done(b_wr_done), .wr_error(b_wr_error), .checksum(b_checksum));

  sdcard_writer #(.MAX_RAM_ADDRESS(25'd2), .SDHC(1'b1)) dut_c (
    .clk50(clk), .reset(rst), .start(start_bc),
    .ram_re(c_ram_re), .ram_address(c_ram_address), .ram_rdata(c_ram_rdata), .ram_rvalid(c_ram_rvalid),
    .sd_wr(c_sd_wr), .sd_continue(c_sd_continue), .sd_block_addr(c_sd_block_addr), .sd_data(c_sd_data),
    .sd_data_next(c_sd_data_next), .sd_data_ack(c_sd_data_ack), .sd_busy(c_sd_busy), .sd_error(16'h0000),
    .wr_done(c_wr_done), .wr_error(c_wr_error), .checksum(c_checksum));

  logic [7:0]  byte_q[$];
  logic [32:0] blk_q[$], b_blk_q[$];
  int          blk_bytes, tot_a, b_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_empty(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT output with no expected entry left", nm);
  endtask

  // A: RAM returns its address one cycle after ram_re; SD acks one cycle after sd_data_next
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ram_rvalid <= 1'b0; a_ram_rdata <= '0; a_sd_busy <= 1'b0;
      a_sd_data_ack <= 1'b0; blk_bytes <= 0; tot_a <= 0;
    end else begin
      a_ram_rvalid <= a_ram_re && !a_ram_rvalid;
      a_ram_rdata  <= a_ram_address[15:0];
      if (a_sd_wr && !a_sd_busy) begin
        a_sd_busy <= 1'b1;
        blk_bytes <= 0;
      end
      if (!a_sd_data_next) begin
        a_sd_data_ack <= 1'b0;
      end else if (!a_sd_data_ack && a_sd_busy) begin
        if (inject && blk_bytes == 11) begin
          a_sd_busy <= 1'b0;
        end else begin
          a_sd_data_ack <= 1'b1;
          blk_bytes     <= blk_bytes + 1;
          tot_a         <= tot_a + 1;
          if (blk_bytes == 511) a_sd_busy <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!inject)
      a_sd_error <= 16'h0000;
    else if (a_sd_data_next && !a_sd_data_ack && a_sd_busy && blk_bytes == 11)
      a_sd_error <= 16'h0004;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (a_sd_wr && !a_sd_busy) begin
        if (blk_q.size() == 0) fail_empty("a_block");
        else begin
          logic [32:0] e;
          e = blk_q.pop_front();
          chk("a_blk_addr", a_sd_block_addr, e[31:0]);
          chk("a_blk_cont", {31'b0, a_sd_continue}, {31'b0, e[32]});
        end
      end
      if (a_sd_data_next && !a_sd_data_ack && a_sd_busy) begin
        if (byte_q.size() == 0) fail_empty("a_byte");
        else chk("a_byte", {24'b0, a_sd_data}, {24'b0, byte_q.pop_front()});
      end
    end
  end

  // B and C: zero-latency RAM and immediate ack
  assign b_ram_rvalid  = b_ram_re;
  assign b_ram_rdata   = b_ram_address[15:0];
  assign b_sd_data_ack = b_sd_data_next;
  assign c_ram_rvalid  = c_ram_re;
  assign c_ram_rdata   = (c_ram_address == '0) ? 16'hFFFF : 16'h0002;
  assign c_sd_data_ack = c_sd_data_next;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b_sd_busy <= 1'b0; b_cnt <= 0; c_sd_busy <= 1'b0;
    end else begin
      if (b_sd_wr && !b_sd_busy) begin
        b_sd_busy <= 1'b1;
        b_cnt     <= 0;
      end else if (b_sd_data_next) begin
        b_cnt <= b_cnt + 1;
        if (b_cnt == 511) b_sd_busy <= 1'b0;
      end
      if (c_sd_wr) c_sd_busy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst && b_sd_wr && !b_sd_busy) begin
      if (b_blk_q.size() == 0) fail_empty("b_block");
      else begin
        logic [32:0] e;
        e = b_blk_q.pop_front();
        chk("b_blk_addr", b_sd_block_addr, e[31:0]);
        chk("b_blk_cont", {31'b0, b_sd_continue}, {31'b0, e[32]});
      end
    end
  end

  task automatic push_dump();
    byte_q.delete();
    blk_q.delete();
    blk_q.push_back({1'b0, 32'd0});
    blk_q.push_back({1'b1, 32'd1});
    for (int i = 0; i < 300; i++) begin
      byte_q.push_back(i[7:0]);
      byte_q.push_back(i[15:8]);
    end
    for (int i = 0; i < 424; i++) byte_q.push_back(8'h00);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(nm, {2'b0, a_sd_wr, a_sd_continue, a_sd_data_next, a_ram_re, a_wr_done, a_wr_error,
             a_sd_data, a_checksum}, 32'd0);
  endtask

  task automatic wait_a_done();
    for (int i = 0; i < 20000 && !a_wr_done; i++) @(negedge clk);
    chk("a_done", {31'b0, a_wr_done}, 32'd1);
    chk("a_error_clear", {31'b0, a_wr_error}, 32'd0);
    chk("a_bytes_left", byte_q.size(), 32'd0);
    chk("a_blocks_left", blk_q.size(), 32'd0);
    chk("a_checksum", {16'b0, a_checksum}, {16'b0, A_SUM});
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; start_bc = 1'b0; inject = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");

    // full dump on all three instances
    push_dump();
    b_blk_q.push_back({1'b0, 32'h0});
    b_blk_q.push_back({1'b1, 32'h200});
    rst = 1'b0;
    @(negedge clk);
    start_bc = 1'b1;
    pulse_start();
    start_bc = 1'b0;
    wait_a_done();
    for (int i = 0; i < 20000 && !(b_wr_done && c_wr_done); i++) @(negedge clk);
    chk("b_done", {31'b0, b_wr_done}, 32'd1);
    chk("b_blocks_left", b_blk_q.size(), 32'd0);
    chk("c_done", {31'b0, c_wr_done}, 32'd1);
    chk("c_checksum", {16'b0, c_checksum}, {16'b0, C_SUM});

    // reset in the middle of the first block, then restart from word 0
    pulse_reset();
    push_dump();
    pulse_start();
    for (int i = 0; i < 5000 && tot_a < 100; i++) @(negedge clk);
    chk("mid_reached_100", {31'b0, tot_a >= 100}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_outputs");
    push_dump();
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_a_done();

    // controller error while the high byte of word 5 is offered
    pulse_reset();
    push_dump();
    inject = 1'b1;
    pulse_start();
    for (int i = 0; i < 5000 && !a_wr_error; i++) @(negedge clk);
    chk("err_flag", {31'b0, a_wr_error}, 32'd1);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (a_sd_wr || a_ram_re) seen = 1'b1;
    end
    chk("err_quiet", {31'b0, seen}, 32'd0);
    chk("err_no_done", {31'b0, a_wr_done}, 32'd0);

    // error code still present after reset: IDLE goes straight to ERROR
    pulse_reset();
    repeat (2) @(negedge clk);
    chk("idle_err", {31'b0, a_wr_error}, 32'd1);
    inject = 1'b0;
    @(negedge clk);
    pulse_reset();
    repeat (2) @(negedge clk);
    chk("idle_clear", {30'b0, a_wr_error, a_wr_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdcard_writer.md
SDCARD_WRITER -- requirements
Module: sdcard_writer

Interface
REQ-001 Parameter MAX_RAM_ADDRESS, default 25'h266F78: number of 16-bit words copied from RAM to the SD card, starting at word 0.
REQ-002 Parameter SDHC, default 1'b1: 1 selects block addressing and 0 selects byte addressing for sd_block_addr.
REQ-003 clk50  in  1  the single clock; all logic is on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse that begins a dump; ignored outside IDLE.
REQ-006 ram_re  out  1  RAM read request, held until ram_rvalid.
REQ-007 ram_address  out  25  word address of the current read.
REQ-008 ram_rdata  in  16  RAM read data; valid while ram_rvalid=1.
REQ-009 ram_rvalid  in  1  RAM read acknowledge carrying the data.
REQ-010 sd_wr  out  1  block-write request to the SD controller.
REQ-011 sd_continue  out  1  multi-block continue flag to the SD controller.
REQ-012 sd_block_addr  out  32  SD block address (SDHC=1) or byte address (SDHC=0).
REQ-013 sd_data  out  8  byte presented to the SD controller.
REQ-014 sd_data_next  out  1  host handshake: sd_data is valid.
REQ-015 sd_data_ack  in  1  controller handshake: byte taken.
REQ-016 sd_busy  in  1  SD controller busy.
REQ-017 sd_error  in  16  SD controller error code; 0 means OK.
REQ-018 wr_done  out  1  dump complete; held high.
REQ-019 wr_error  out  1  SD error detected; held high.
REQ-020 checksum  out  16  running word sum (see Configuration).

Function
REQ-021 The state machine SHALL have the states IDLE, WRBLOCK, FETCH, WRL_0, WRL_1, WRH_0, WRH_1, PAD_0, PAD_1, ERROR and DONE.
REQ-022 IDLE -> ERROR SHALL occur when sd_busy=0 and sd_error!=0; IDLE -> WRBLOCK SHALL occur on start=1 with sd_busy=0 and sd_error=0.
REQ-023 WRBLOCK: if addr>=MAX_RAM_ADDRESS the block SHALL go to DONE; otherwise it SHALL assert sd_wr, assert sd_continue when sd_block_addr!=0, and move to FETCH when sd_busy=1.
REQ-024 sd_block_addr SHALL be addr>>8 when SDHC=1 and addr<<1 when SDHC=0, zero-extended to 32 bits; one block holds 256 words (512 bytes).
REQ-025 FETCH: the block SHALL assert ram_re; on ram_rvalid it SHALL latch ram_rdata into the word register and move to WRL_0.
REQ-026 Byte order SHALL be the low byte [7:0] first, then the high byte [15:8].
REQ-027 WRL_0 and WRH_0 SHALL drive sd_data and assert sd_data_next until sd_data_ack=1, then move to WRL_1 or WRH_1 respectively.
REQ-028 WRL_1 and WRH_1 SHALL deassert sd_data_next and wait for sd_data_ack=0; WRL_1 then goes to WRH_0.
REQ-029 When WRH_1 completes, addr SHALL increment by 1, with the next state chosen as follows:
  - addr[7:0] wrapped to 0 -> WRBLOCK;
  - new addr>=MAX_RAM_ADDRESS with addr[7:0]!=0 -> PAD_0;
  - otherwise -> FETCH.
REQ-030 PAD_0/PAD_1 SHALL send byte 0x00 with the same handshake until the 512-byte block is full, then go to WRBLOCK; addr SHALL NOT advance during padding.
REQ-031 In any writing state, sd_busy=0 with sd_error!=0 SHALL force ERROR.
REQ-032 ERROR and DONE SHALL be terminal until reset; wr_error=1 in ERROR and wr_done=1 in DONE.
REQ-033 Exactly one RAM read SHALL be outstanding at a time; ram_address SHALL equal addr.

Reset
REQ-034 Asserting reset at any time, including mid-block, SHALL immediately force state IDLE, addr=0, word register 0 and checksum 0.
REQ-035 During reset all outputs SHALL be 0: sd_wr, sd_continue, sd_data_next, ram_re, wr_done, wr_error, sd_data and checksum.

Configuration
REQ-036 Macro SDCARD_WR_CHECKSUM_EN is the single compile-time option.
REQ-037 With SDCARD_WR_CHECKSUM_EN defined, checksum SHALL add each latched word modulo 2^16; pad bytes are excluded.
REQ-038 Without SDCARD_WR_CHECKSUM_EN, checksum SHALL be constant 0 and no adder is built.

Verification
REQ-039 MAX_RAM_ADDRESS=256, SDHC=1, RAM word=i: the bench SHALL see one block at sd_block_addr=0 with sd_continue=0, bytes 00,00,01,00,...,FF,00, then wr_done=1.
REQ-040 MAX_RAM_ADDRESS=300: the bench SHALL see block 1 with sd_continue=1, 44 words followed by 424 bytes of 0x00, then wr_done.
REQ-041 SDHC=0, MAX_RAM_ADDRESS=512: the second block SHALL use sd_block_addr=0x200.
REQ-042 sd_error=0x0004 with sd_busy=0 during WRH_0 -> wr_error=1, with no further sd_wr or ram_re.
REQ-043 Reset pulse after 100 bytes, then start -> the dump SHALL restart at addr 0 and sd_block_addr 0.
REQ-044 SDCARD_WR_CHECKSUM_EN with words 0xFFFF,0x0002 and MAX_RAM_ADDRESS=2 -> checksum=0x0001; without the macro -> checksum=0.
